lcd_bus_scheduler: RTL and testbench
====================================

Name: lcd_bus_scheduler

Overview:
- Owns the character-LCD bus (lcd_data, lcd_rs, lcd_rw, lcd_en) and shares it between two byte-write requesters, e.g. the game-text writer (port 0) and the status/score writer (port 1).
- Runs the power-up init sequence once, then arbitrates round-robin.
- Generates setup, enable-pulse, hold and execution-wait timing per write.
- Sits between the game-state logic and the LCD pins, replacing free-running, clock-divider-driven LCD strobing.

Parameters:
- SETUP_CYC, 4, clk_50Mhz cycles from rs/data valid to lcd_en rise.
- EN_CYC, 25, cycles lcd_en held high.
- HOLD_CYC, 4, cycles rs/data held after lcd_en fall.
- SHORT_WAIT_CYC, 2000, execution wait for ordinary commands and data (40 us).
- LONG_WAIT_CYC, 82000, execution wait for clear/home (1.64 ms).
- PWRUP_CYC, 750000, delay after reset before the first init write (15 ms).

Ports:
- clk_50Mhz  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 has a byte to write
- req0_rs  input  1  requester 0 register select (0 = command, 1 = data)
- req0_data  input  8  requester 0 byte
- req0_ready  output  1  requester 0 byte accepted this cycle
- req1_valid  input  1  requester 1 has a byte to write
- req1_rs  input  1  requester 1 register select
- req1_data  input  8  requester 1 byte
- req1_ready  output  1  requester 1 byte accepted this cycle
- init_done  output  1  init sequence complete; stays high until reset
- busy  output  1  a write or init is in progress
- lcd_data  output  8  LCD data bus
- lcd_rs  output  1  LCD register select
- lcd_rw  output  1  LCD read/write; always 0 (write only)
- lcd_en  output  1  LCD enable strobe

Behaviour:
- Clock and reset: single clock, clk_50Mhz. Reset is synchronous and active-high on port reset.
- Reset values: lcd_data = 0x00, lcd_rs = 0, lcd_rw = 0, lcd_en = 0, req0_ready = 0, req1_ready = 0, init_done = 0, busy = 1, last_grant = 1, state = PWRUP, counter loaded with PWRUP_CYC.
- FSM states: PWRUP, INIT_LOAD, IDLE, SETUP, EN_HI, HOLD, WAIT.
- PWRUP: count PWRUP_CYC cycles, then go to INIT_LOAD with idx = 0.
- INIT_LOAD: latch rs = 0 and data = INIT_ROM[idx], then go to SETUP.
  - INIT_ROM = 0x38, 0x0C, 0x01, 0x06.
- SETUP: lcd_en = 0 for SETUP_CYC cycles.
- EN_HI: lcd_en = 1 for exactly EN_CYC cycles. lcd_en is driven from a register.
- HOLD: lcd_en = 0 for HOLD_CYC cycles. rs/data stay unchanged through SETUP, EN_HI and HOLD.
- WAIT: count the execution wait.
  - LONG_WAIT_CYC when rs = 0 and data[7:2] = 0 (0x01, 0x02, 0x03).
  - SHORT_WAIT_CYC otherwise.
  - Exit during init: idx < 3 goes to INIT_LOAD with idx+1; idx = 3 sets init_done and goes to IDLE.
  - Exit after init: go to IDLE.
- IDLE: busy = 0. reqN_ready is combinational and asserted only in IDLE with init_done = 1.
  - If only one requester is valid, that requester is ready.
  - If both are valid, ready goes to the requester other than last_grant.
  - Never both ready in the same cycle.
- Accept: the handshake completes on a cycle where reqN_valid & reqN_ready.
  - rs/data latch on that edge and drive lcd_rs/lcd_data from the next cycle.
  - last_grant <= N; state goes to SETUP.
- Requester rules:
  - A requester holds valid, rs and data stable until it sees ready.
  - Dropping valid before acceptance withdraws the request with no side effect.
  - Requests made before init_done wait; they are not lost and not acknowledged.
- Latency: lcd_en rises SETUP_CYC+1 cycles after the accept edge. Earliest next ready is SETUP_CYC+EN_CYC+HOLD_CYC+WAIT+1 cycles after the accept edge.
- busy = 1 in every state except IDLE.
- Reset mid-write: everything returns to reset values in the next cycle, including lcd_en low and init rerun.
- Counter: one shared down-counter, 20 bits wide (fits 750000). A load of N gives exactly N cycles in the state. Every timing parameter must be ≥ 1.

Decomposition:
- Package lcd_pkg holds:
  - the state enum;
  - INIT_ROM constants;
  - command codes CLEAR = 0x01, HOME = 0x02, FUNCSET = 0x38, DISPON = 0x0C, ENTRY = 0x06;
  - the is_long_cmd(rs, data) function.
- Sub-module lcd_write_timer: loadable 20-bit down-counter with a done flag. The FSM, arbiter and data registers stay in lcd_bus_scheduler.

Test Plan:
Bench parameters: SETUP_CYC = 2, EN_CYC = 3, HOLD_CYC = 2, SHORT_WAIT_CYC = 10, LONG_WAIT_CYC = 40, PWRUP_CYC = 20.
1. Init: release reset, no requests. Expect 4 lcd_en pulses, each 3 cycles high, with data 0x38, 0x0C, 0x01, 0x06 and rs = 0. Gap after 0x01 is long (40), the others are short (10). init_done rises after the 0x06 wait; busy then drops.
2. Single write: req0 valid, rs = 1, data = 0x41 after init. req0_ready pulses 1 cycle; lcd_data = 0x41 and lcd_rs = 1 next cycle; lcd_en high 3 cycles starting 3 cycles after accept; next ready no earlier than 18 cycles after accept.
3. Contention: both valid continuously, req0 = 0x30, req1 = 0x31, rs = 1. Grants alternate req0, req1, req0, req1; ready is never high on both; the bus shows 0x30, 0x31, 0x30, 0x31.
4. Early request: req1 valid with 0x55 during PWRUP. No ready until init_done. 0x55 is the first byte written after the init sequence.
5. Long command: req0 rs = 0, data = 0x02. WAIT lasts 40 cycles. Then req0 rs = 0, data = 0x80: WAIT lasts 10 cycles.
6. Reset mid-write: assert reset while lcd_en = 1. Next cycle lcd_en = 0, busy = 1, init_done = 0; the full init sequence repeats.

Source files
------------

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types, command codes and helpers for the LCD bus scheduler
package lcd_pkg;

    localparam int TIMER_W = 20;

    typedef enum logic [2:0] {
        PWRUP,
        INIT_LOAD,
        IDLE,
        SETUP,
        EN_HI,
        HOLD,
        WAIT
    } lcd_state_t;

    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] CMD_HOME    = 8'h02;
    localparam logic [7:0] CMD_FUNCSET = 8'h38;
    localparam logic [7:0] CMD_DISPON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;

    // Element 0 is issued first.
    localparam logic [3:0][7:0] INIT_ROM = {CMD_ENTRY, CMD_CLEAR, CMD_DISPON, CMD_FUNCSET};

    // Clear and home (and the 0x03 home alias) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0);
    endfunction

endpackage

// File: rtl/lcd_write_timer.sv
// rtl/lcd_write_timer.sv - loadable down-counter; a load of N keeps done low for N-1 cycles then high for one
module lcd_write_timer
    import lcd_pkg::*;
#(
    parameter int RESET_VAL = 1
) (
    input  logic               clk_50Mhz,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic               done
);

    logic [TIMER_W-1:0] cnt;

    always_ff @(posedge clk_50Mhz) begin
        if (reset) begin
            cnt <= TIMER_W'(RESET_VAL);
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - TIMER_W'(1);
        end
    end

    // done on the last cycle of the interval so the FSM leaves exactly N cycles after the load
    assign done = (cnt == TIMER_W'(1));

endmodule

// File: rtl/lcd_bus_scheduler.sv
// rtl/lcd_bus_scheduler.sv - character-LCD bus owner: init sequence, round-robin arbitration, write timing
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC      = 4,
    parameter int EN_CYC         = 25,
    parameter int HOLD_CYC       = 4,
    parameter int SHORT_WAIT_CYC = 2000,
    parameter int LONG_WAIT_CYC  = 82000,
    parameter int PWRUP_CYC      = 750000
) (
    input  logic       clk_50Mhz,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    lcd_state_t         state, state_nxt;
    logic [1:0]         idx;
    logic               last_grant;
    logic               t_load;
    logic [TIMER_W-1:0] t_val;
    logic               t_done;
    logic               grant0, grant1;

    lcd_write_timer #(
        .RESET_VAL (PWRUP_CYC)
    ) u_timer (
        .clk_50Mhz (clk_50Mhz),
        .reset     (reset),
        .load      (t_load),
        .load_val  (t_val),
        .done      (t_done)
    );

    // Round-robin: on contention the port that did not win last time goes first.
    assign grant0 = req0_valid && (!req1_valid || last_grant);
    assign grant1 = req1_valid && (!req0_valid || !last_grant);

    always_comb begin
        state_nxt  = state;
        t_load     = 1'b0;
        t_val      = '0;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            PWRUP: begin
                if (t_done) state_nxt = INIT_LOAD;
            end
            INIT_LOAD: begin
                state_nxt = SETUP;
                t_load    = 1'b1;
                t_val     = TIMER_W'(SETUP_CYC);
            end
            IDLE: begin
                if (init_done) begin
                    req0_ready = grant0;
                    req1_ready = grant1;
                    if (grant0 || grant1) begin
                        state_nxt = SETUP;
                        t_load    = 1'b1;
                        t_val     = TIMER_W'(SETUP_CYC);
                    end
                end
            end
            SETUP: begin
                if (t_done) begin
                    state_nxt = EN_HI;
                    t_load    = 1'b1;
                    t_val     = TIMER_W'(EN_CYC);
                end
            end
            EN_HI: begin
                if (t_done) begin
                    state_nxt = HOLD;
                    t_load    = 1'b1;
                    t_val     = TIMER_W'(HOLD_CYC);
                end
            end
            HOLD: begin
                if (t_done) begin
                    state_nxt = WAIT;
                    t_load    = 1'b1;
                    t_val     = is_long_cmd(lcd_rs, lcd_data) ? TIMER_W'(LONG_WAIT_CYC)
                                                              : TIMER_W'(SHORT_WAIT_CYC);
                end
            end
            WAIT: begin
                if (t_done) begin
                    state_nxt = (!init_done && idx != 2'd3) ? INIT_LOAD : IDLE;
                end
            end
            default: state_nxt = PWRUP;
        endcase
    end

    always_ff @(posedge clk_50Mhz) begin
        if (reset) begin
            state      <= PWRUP;
            idx        <= 2'd0;
            lcd_rs     <= 1'b0;
            lcd_data   <= 8'h00;
            lcd_en     <= 1'b0;
            last_grant <= 1'b1;
            init_done  <= 1'b0;
        end else begin
            state  <= state_nxt;
            // Registered strobe that is high exactly for the EN_HI cycles.
            lcd_en <= (state_nxt == EN_HI);
            if (state == PWRUP && t_done) begin
                idx <= 2'd0;
            end
            if (state == INIT_LOAD) begin
                lcd_rs   <= 1'b0;
                lcd_data <= INIT_ROM[idx];
            end
            if (req0_ready) begin
                lcd_rs     <= req0_rs;
                lcd_data   <= req0_data;
                last_grant <= 1'b0;
            end else if (req1_ready) begin
                lcd_rs     <= req1_rs;
                lcd_data   <= req1_data;
                last_grant <= 1'b1;
            end
            if (state == WAIT && t_done && !init_done) begin
                if (idx == 2'd3) init_done <= 1'b1;
                else             idx       <= idx + 2'd1;
            end
        end
    end

    assign busy   = (state != IDLE);
    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// tb/tb_lcd_bus_scheduler.sv - randomized self-checking bench for lcd_bus_scheduler
module tb_lcd_bus_scheduler;

    localparam int SETUP = 2;
    localparam int ENC   = 3;
    localparam int HOLD  = 2;
    localparam int SHORT = 10;
    localparam int LONG  = 40;
    localparam int PWRUP = 20;

    typedef struct {
        logic [8:0] b;
        int         rise;
    } wr_t;

    logic       clk_50Mhz = 1'b0;
    logic       reset = 1'b1;
    logic       req0_valid = 1'b0, req0_rs = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req1_valid = 1'b0, req1_rs = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req0_ready, req1_ready, init_done, busy, lcd_rs, lcd_rw, lcd_en;
    logic [7:0] lcd_data;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    wr_t        q[$];
    int         idle_at = 0;
    int         init_idle_exp = 0;
    logic       model_last = 1'b1;
    logic       p0 = 1'b0, p1 = 1'b0;
    logic [8:0] b0 = '0, b1 = '0;
    int         vs0 = 0, vs1 = 0;
    logic [7:0] rom[4] = '{8'h38, 8'h0C, 8'h01, 8'h06};

    logic       en_prev = 1'b0;
    int         hi_cnt = 0;
    logic [8:0] cur = '0;

    lcd_bus_scheduler #(
        .SETUP_CYC      (SETUP),
        .EN_CYC         (ENC),
        .HOLD_CYC       (HOLD),
        .SHORT_WAIT_CYC (SHORT),
        .LONG_WAIT_CYC  (LONG),
        .PWRUP_CYC      (PWRUP)
    ) dut (
        .clk_50Mhz  (clk_50Mhz),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_rs    (req0_rs),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_rs    (req1_rs),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .init_done  (init_done),
        .busy       (busy),
        .lcd_data   (lcd_data),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en)
    );

    always #5 clk_50Mhz = ~clk_50Mhz;

    initial forever begin
        @(posedge clk_50Mhz);
        cyc++;
    end

    task automatic check(input string tag, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic finish_sim();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    endtask

    function automatic int exec_wait(input logic rs, input logic [7:0] d);
        return (rs == 1'b0 && d < 8'd4) ? LONG : SHORT;
    endfunction

    // Expected init writes: fixed bytes, rise times derived from the timing rules.
    task automatic start_init(input int c0);
        int r;
        int last;
        q.delete();
        r    = c0 + PWRUP + SETUP + 1;
        last = r;
        for (int k = 0; k < 4; k++) begin
            q.push_back('{{1'b0, rom[k]}, r});
            last = r;
            r    = r + ENC + HOLD + exec_wait(1'b0, rom[k]) + 1 + SETUP;
        end
        init_idle_exp = last + ENC + HOLD + exec_wait(1'b0, rom[3]);
        model_last    = 1'b1;
        p0 = 1'b0;
        p1 = 1'b0;
    endtask

    task automatic raise(input int port, input logic rs, input logic [7:0] d);
        if (port == 0) begin
            req0_valid = 1'b1; req0_rs = rs; req0_data = d;
            p0 = 1'b1; b0 = {rs, d}; vs0 = cyc;
        end else begin
            req1_valid = 1'b1; req1_rs = rs; req1_data = d;
            p1 = 1'b1; b1 = {rs, d}; vs1 = cyc;
        end
    endtask

    // Wait for one grant and check its cycle and port against the arbitration model.
    task automatic serve(output int rc, output int port);
        int n;
        int vmin;
        int exp_c;
        int exp_p;
        n = 0;
        @(negedge clk_50Mhz);
        while (!(req0_ready || req1_ready) && n < 3000) begin
            @(negedge clk_50Mhz);
            n++;
        end
        if (!(req0_ready || req1_ready)) begin
            check("ready_timeout", 0, 1);
            finish_sim();
        end
        vmin  = (p0 && p1) ? ((vs0 < vs1) ? vs0 : vs1) : (p0 ? vs0 : vs1);
        exp_c = (vmin > idle_at) ? vmin : idle_at;
        exp_p = (p0 && p1) ? (model_last ? 0 : 1) : (p0 ? 0 : 1);
        port  = req1_ready ? 1 : 0;
        rc    = cyc;
        check("ready_cycle", cyc, exp_c);
        check("grant_port", port, exp_p);
        check("idle_busy", busy, 0);
        q.push_back('{(exp_p == 1) ? b1 : b0, cyc + SETUP + 1});
        model_last = (exp_p == 1);
        @(posedge clk_50Mhz);
        #1;
        if (port == 0) begin req0_valid = 1'b0; p0 = 1'b0; end
        else           begin req1_valid = 1'b0; p1 = 1'b0; end
    endtask

    // Bus monitor: every strobe must match the next expected write in byte, time and width.
    initial forever begin
        wr_t e;
        @(negedge clk_50Mhz);
        if (reset) begin
            en_prev = 1'b0;
            hi_cnt  = 0;
        end else begin
            if (req0_ready || req1_ready) begin
                check("single_ready", req0_ready && req1_ready, 0);
                check("ready_after_init", init_done, 1);
            end
            if (lcd_en && !en_prev) begin
                check("write_expected", q.size() > 0, 1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("wr_byte", {lcd_rs, lcd_data}, e.b);
                    check("rise_cycle", cyc, e.rise);
                end
                check("rw_low", lcd_rw, 0);
                check("busy_write", busy, 1);
                cur     = {lcd_rs, lcd_data};
                hi_cnt  = 1;
                idle_at = cyc + ENC + HOLD + exec_wait(lcd_rs, lcd_data);
            end else if (lcd_en) begin
                hi_cnt++;
                check("bus_stable", {lcd_rs, lcd_data}, cur);
            end else if (en_prev) begin
                check("en_width", hi_cnt, ENC);
            end
            en_prev = lcd_en;
        end
    end

    initial begin
        int rc, port, r1, r2, r3, n;
        logic [7:0] d;

        // Reset values
        repeat (2) @(posedge clk_50Mhz);
        @(negedge clk_50Mhz);
        check("rst_lcd_en", lcd_en, 0);
        check("rst_busy", busy, 1);
        check("rst_init_done", init_done, 0);
        check("rst_lcd_data", lcd_data, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_ready", {req0_ready, req1_ready}, 0);
        @(posedge clk_50Mhz);
        #1 reset = 1'b0;
        start_init(cyc);

        // Init sequence with no requests
        n = 0;
        @(negedge clk_50Mhz);
        while (!init_done && n < 2000) begin
            @(negedge clk_50Mhz);
            n++;
        end
        check("init_done_cycle", cyc, init_idle_exp);
        check("busy_after_init", busy, 0);
        check("init_writes_done", q.size(), 0);

        // Single write, then a withdrawn request while busy
        @(posedge clk_50Mhz);
        #1 raise(0, 1'b1, 8'h41);
        serve(rc, port);
        @(negedge clk_50Mhz);
        check("single_data", lcd_data, 8'h41);
        check("single_rs", lcd_rs, 1);
        check("single_ready_pulse", req0_ready, 0);
        @(posedge clk_50Mhz);
        #1 raise(1, 1'b1, 8'h99);
        repeat (3) @(posedge clk_50Mhz);
        #1;
        req1_valid = 1'b0;
        p1 = 1'b0;
        raise(1, 1'b1, 8'h42);
        serve(rc, port);

        // Contention: both requesters held valid
        raise(0, 1'b1, 8'h30);
        raise(1, 1'b1, 8'h31);
        for (int i = 0; i < 4; i++) begin
            serve(rc, port);
            check("contention_port", port, i % 2);
            if (port == 0) raise(0, 1'b1, 8'h30);
            else           raise(1, 1'b1, 8'h31);
        end
        serve(rc, port);
        serve(rc, port);

        // Long then short command wait
        raise(0, 1'b0, 8'h02);
        serve(r1, port);
        raise(0, 1'b0, 8'h80);
        serve(r2, port);
        raise(0, 1'b1, 8'h20);
        serve(r3, port);
        check("long_wait_gap", r2 - r1, SETUP + ENC + HOLD + LONG + 1);
        check("short_wait_gap", r3 - r2, SETUP + ENC + HOLD + SHORT + 1);

        // Random traffic
        for (int i = 0; i < 24; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk_50Mhz);
            #1;
            d = 8'($urandom_range(0, 255));
            if (!p0 && $urandom_range(0, 1) == 1) raise(0, 1'($urandom_range(0, 1)), d);
            d = 8'($urandom_range(0, 7));
            if (!p1 && $urandom_range(0, 1) == 1) raise(1, 1'($urandom_range(0, 1)), d);
            if (!p0 && !p1) raise(int'($urandom_range(0, 1)), 1'b1, 8'($urandom_range(0, 255)));
            serve(rc, port);
        end
        while (p0 || p1) serve(rc, port);

        // Reset in the middle of an enable pulse, with an early request during power-up
        raise(0, 1'b1, 8'h77);
        serve(rc, port);
        n = 0;
        @(negedge clk_50Mhz);
        while (!lcd_en && n < 100) begin
            @(negedge clk_50Mhz);
            n++;
        end
        check("saw_en_before_reset", lcd_en, 1);
        #1 reset = 1'b1;
        @(posedge clk_50Mhz);
        @(negedge clk_50Mhz);
        check("midrst_lcd_en", lcd_en, 0);
        check("midrst_busy", busy, 1);
        check("midrst_init_done", init_done, 0);
        @(posedge clk_50Mhz);
        #1 reset = 1'b0;
        start_init(cyc);
        raise(1, 1'b1, 8'h55);
        serve(rc, port);
        check("early_req_at_init_end", rc, init_idle_exp);
        raise(0, 1'b1, 8'h66);
        serve(rc, port);

        n = 0;
        @(negedge clk_50Mhz);
        while (busy && n < 200) begin
            @(negedge clk_50Mhz);
            n++;
        end
        check("drain_idle", busy, 0);
        check("all_writes_seen", q.size(), 0);
        finish_sim();
    end

endmodule
